// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds the {S,Z,C,V} flag register, resolves conditional branches and
// offers the target PC to fetch over a valid/ready handshake. Optional counters: BR_PERF_CNT_EN.
module branch_cond_unit #(
    parameter int PC_W   = 16,
    parameter int DISP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic              s_in,
    input  logic              z_in,
    input  logic              c_in,
    input  logic              v_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [DISP_W-1:0] br_disp,
    output logic              br_done,
    output logic              br_taken,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [3:0]        flags_q
`ifdef BR_PERF_CNT_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       nt_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;
    localparam logic [2:0] COND_B   = 3'b100;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_flags;
    logic              r_br_done;
    logic              r_br_taken;
    logic [PC_W-1:0]   r_redirect_pc;

    logic              w_eff_s;
    logic              w_eff_z;
    logic              w_eff_v;
    logic              w_cond_true;
    logic              w_accept;
    logic              w_take;
    logic [PC_W-1:0]   w_disp_sext;
    logic [PC_W-1:0]   w_target;

    // A flag write in the same cycle as the branch is visible to that branch.
    assign w_eff_s = flag_we ? s_in : r_flags[3];
    assign w_eff_z = flag_we ? z_in : r_flags[2];
    assign w_eff_v = flag_we ? v_in : r_flags[0];

    always_comb begin
        w_cond_true = 1'b0;
        case (br_cond)
            COND_BE:  w_cond_true = w_eff_z;
            COND_BLT: w_cond_true = w_eff_s ^ w_eff_v;
            COND_BLE: w_cond_true = w_eff_z | (w_eff_s ^ w_eff_v);
            COND_BNE: w_cond_true = ~w_eff_z;
            COND_B:   w_cond_true = 1'b1;
            default:  w_cond_true = 1'b0;
        endcase
    end

    assign w_disp_sext = {{(PC_W-DISP_W){br_disp[DISP_W-1]}}, br_disp};
    assign w_target    = br_pc + PC_W'(1) + w_disp_sext;
    assign w_take      = w_accept & w_cond_true;

    always_comb begin
        w_state_next = r_state;
        br_ready     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                br_ready = 1'b1;
                w_accept = br_valid;
                if (br_valid && w_cond_true) begin
                    w_state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_flags       <= 4'b0000;
            r_br_done     <= 1'b0;
            r_br_taken    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_state    <= w_state_next;
            r_br_done  <= w_accept;
            r_br_taken <= w_take;
            if (flag_we) begin
                r_flags <= {s_in, z_in, c_in, v_in};
            end
            if (w_take) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    assign br_done        = r_br_done;
    assign br_taken       = r_br_taken;
    assign redirect_valid = (r_state == ST_REDIRECT);
    assign redirect_pc    = r_redirect_pc;
    assign flags_q        = r_flags;

`ifdef BR_PERF_CNT_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_nt_cnt;

    // Counts follow the registered result pulse, so they lag br_done by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_cnt <= 16'h0000;
            r_nt_cnt    <= 16'h0000;
        end else if (r_br_done) begin
            if (r_br_taken) begin
                r_taken_cnt <= r_taken_cnt + 16'h0001;
            end else begin
                r_nt_cnt <= r_nt_cnt + 16'h0001;
            end
        end
    end

    assign taken_cnt = r_taken_cnt;
    assign nt_cnt    = r_nt_cnt;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: directed steps followed by random traffic, all checked
// against a cycle-level behavioural model of the flag register and branch handshake.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flag_we;
    logic        s_in, z_in, c_in, v_in;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_pc;
    logic [7:0]  br_disp;
    logic        br_done;
    logic        br_taken;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [15:0] redirect_pc;
    logic [3:0]  flags_q;
`ifdef BR_PERF_CNT_EN
    logic [15:0] taken_cnt;
    logic [15:0] nt_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model state: what the outputs should read just after each rising edge.
    logic [3:0]  m_flags;
    bit          m_redir;
    logic [15:0] m_pc;
    bit          m_done;
    bit          m_taken;
    logic [15:0] m_tcnt;
    logic [15:0] m_ncnt;

    always #5 clk = ~clk;

    branch_cond_unit #(.PC_W(16), .DISP_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .flag_we        (flag_we),
        .s_in           (s_in),
        .z_in           (z_in),
        .c_in           (c_in),
        .v_in           (v_in),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_pc          (br_pc),
        .br_disp        (br_disp),
        .br_done        (br_done),
        .br_taken       (br_taken),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flags_q        (flags_q)
`ifdef BR_PERF_CNT_EN
        ,
        .taken_cnt      (taken_cnt),
        .nt_cnt         (nt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [2:0] cond, input logic [3:0] f);
        bit s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (cond)
            3'd0:    return z;
            3'd1:    return s != v;
            3'd2:    return z || (s != v);
            3'd3:    return !z;
            3'd4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all(input string step);
        chk({step, "_ready"},  {31'd0, br_ready},       {31'd0, !m_redir});
        chk({step, "_done"},   {31'd0, br_done},        {31'd0, m_done});
        chk({step, "_taken"},  {31'd0, br_taken},       {31'd0, m_taken});
        chk({step, "_rvalid"}, {31'd0, redirect_valid}, {31'd0, m_redir});
        chk({step, "_rpc"},    {16'd0, redirect_pc},    {16'd0, m_pc});
        chk({step, "_flags"},  {28'd0, flags_q},        {28'd0, m_flags});
`ifdef BR_PERF_CNT_EN
        chk({step, "_tcnt"},   {16'd0, taken_cnt},      {16'd0, m_tcnt});
        chk({step, "_ncnt"},   {16'd0, nt_cnt},         {16'd0, m_ncnt});
`endif
    endtask

    // One clock: drive inputs, advance the model, check every output after the edge.
    task automatic apply(input string step, input bit rst, input bit fwe, input logic [3:0] fl,
                         input bit bv, input logic [2:0] cond, input logic [15:0] pc,
                         input logic [7:0] disp, input bit rr);
        logic [3:0] eff;
        bit         acc, tk;
        int         tgt;
        reset = rst; flag_we = fwe;
        s_in = fl[3]; z_in = fl[2]; c_in = fl[1]; v_in = fl[0];
        br_valid = bv; br_cond = cond; br_pc = pc; br_disp = disp; redirect_ready = rr;
        @(posedge clk);
        #1;
        if (rst) begin
            m_flags = 4'd0; m_redir = 0; m_pc = 16'd0; m_done = 0; m_taken = 0;
            m_tcnt = 16'd0; m_ncnt = 16'd0;
        end else begin
            if (m_done && m_taken) m_tcnt = m_tcnt + 16'd1;
            if (m_done && !m_taken) m_ncnt = m_ncnt + 16'd1;
            eff = fwe ? fl : m_flags;
            acc = bv && !m_redir;
            tk  = acc && cond_holds(cond, eff);
            if (m_redir && rr) m_redir = 0;
            if (tk) begin
                tgt     = int'(pc) + 1 + int'($signed(disp));
                m_pc    = 16'(tgt);
                m_redir = 1;
            end
            m_done  = acc;
            m_taken = tk;
            if (fwe) m_flags = fl;
        end
        check_all(step);
    endtask

    initial begin
        m_flags = 4'd0; m_redir = 0; m_pc = 16'd0; m_done = 0; m_taken = 0;
        m_tcnt = 16'd0; m_ncnt = 16'd0;

        // Reset state
        apply("rst0", 1, 0, 4'h0, 0, 3'd0, 16'h0, 8'h0, 0);
        apply("rst1", 1, 0, 4'h0, 0, 3'd0, 16'h0, 8'h0, 0);
        chk("rst_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_flags", {28'd0, flags_q}, 32'd0);

        // 1: Z written, then BE taken to 0x0016
        apply("t1a", 0, 1, 4'b0100, 0, 3'd0, 16'h0000, 8'h00, 0);
        apply("t1b", 0, 0, 4'b0000, 1, 3'd0, 16'h0010, 8'h05, 0);
        chk("t1_taken", {31'd0, br_taken}, 32'd1);
        chk("t1_rpc", {16'd0, redirect_pc}, 32'h0016);
        apply("t1c", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1);

        // 2: bypassed Z=0 makes BNE taken, backward displacement
        apply("t2a", 0, 1, 4'b0000, 1, 3'd3, 16'h0100, 8'hFE, 0);
        chk("t2_rpc", {16'd0, redirect_pc}, 32'h00FF);
        apply("t2b", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1);

        // 3: BLT taken with S^V, then BLE with S=V, Z=0 not taken
        apply("t3a", 0, 1, 4'b1000, 1, 3'd1, 16'h0200, 8'h10, 0);
        chk("t3_blt", {31'd0, br_taken}, 32'd1);
        apply("t3b", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1);
        apply("t3c", 0, 1, 4'b1001, 1, 3'd2, 16'h0300, 8'h10, 0);
        chk("t3_ble_done", {31'd0, br_done}, 32'd1);
        chk("t3_ble_taken", {31'd0, br_taken}, 32'd0);
        chk("t3_ble_rvalid", {31'd0, redirect_valid}, 32'd0);

        // 4: redirect stalled for three cycles, then accepted
        apply("t4a", 0, 0, 4'b0000, 1, 3'd4, 16'h1234, 8'h20, 0);
        for (int i = 0; i < 3; i++) begin
            apply("t4s", 0, 0, 4'b0000, 1, 3'd4, 16'h0000, 8'h00, 0);
            chk("t4_stable_pc", {16'd0, redirect_pc}, 32'h1255);
            chk("t4_stall_ready", {31'd0, br_ready}, 32'd0);
        end
        apply("t4b", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1);
        chk("t4_idle_ready", {31'd0, br_ready}, 32'd1);
        chk("t4_idle_rvalid", {31'd0, redirect_valid}, 32'd0);

        // 5: target wraps to zero; reserved condition never taken
        apply("t5a", 0, 0, 4'b0000, 1, 3'd4, 16'hFFFF, 8'h00, 0);
        chk("t5_wrap", {16'd0, redirect_pc}, 32'h0000);
        apply("t5b", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1);
        apply("t5c", 0, 1, 4'b1111, 1, 3'd7, 16'h0040, 8'h01, 0);
        chk("t5_rsvd", {31'd0, br_taken}, 32'd0);

        // 6: reset mid-redirect drops the redirect and clears flags
        apply("t6a", 0, 1, 4'b1010, 1, 3'd4, 16'h0500, 8'h03, 0);
        apply("t6b", 1, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 0);
        chk("t6_rvalid", {31'd0, redirect_valid}, 32'd0);
        chk("t6_flags", {28'd0, flags_q}, 32'd0);
        chk("t6_ready", {31'd0, br_ready}, 32'd1);

        // Three taken and two not-taken branches
        for (int i = 0; i < 3; i++) begin
            apply("c_tk", 0, 0, 4'b0000, 1, 3'd4, 16'h0600, 8'h01, 0);
            apply("c_rl", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 1);
        end
        apply("c_nt0", 0, 0, 4'b0000, 1, 3'd6, 16'h0700, 8'h01, 0);
        apply("c_nt1", 0, 0, 4'b0000, 1, 3'd5, 16'h0700, 8'h01, 0);
        apply("c_end", 0, 0, 4'b0000, 0, 3'd0, 16'h0000, 8'h00, 0);
`ifdef BR_PERF_CNT_EN
        chk("cnt_taken", {16'd0, taken_cnt}, 32'd3);
        chk("cnt_nt", {16'd0, nt_cnt}, 32'd2);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            apply("rnd", $urandom_range(0, 63) == 0, 1'($urandom), 4'($urandom),
                  1'($urandom), 3'($urandom), 16'($urandom), 8'($urandom),
                  $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
